spi_master: RTL and testbench
=============================

Name: spi_master

Overview:
- Initiator end of the single-wire-per-direction SPI link used by the team's SPI slave memory (32 x 8 storage).
- Accepts a parallel write or read request from a local host.
- Serialises opcode, address and data on mosi, one bit per clk, LSB first; collects read data on miso.
- Reports completion when the slave pulses op_done.

Parameters:
- ADDR_W, 8, address field width in bits.
- DATA_W, 8, data field width in bits.
- TIMEOUT, 64, max clk cycles to wait for the slave's ready/op_done (only with SPI_MASTER_TIMEOUT_EN).

Ports:
- clk  input  1  system clock; also the bit clock, one bit per rising edge.
- rst  input  1  asynchronous, active-high reset.
- newd  input  1  host request strobe; sampled only in IDLE.
- wr  input  1  1 = write, 0 = read; latched with newd.
- addr  input  ADDR_W  target address; latched with newd.
- wdata  input  DATA_W  write data; latched with newd.
- cs  output  1  chip select to slave, active high.
- mosi  output  1  serial data to slave.
- miso  input  1  serial data from slave.
- ready  input  1  slave pulse: read data follows starting next cycle.
- op_done  input  1  slave pulse: transaction finished.
- busy  output  1  high from accepted newd until done.
- done  output  1  one-cycle completion pulse.
- rdata  output  DATA_W  read result; valid with done on a read, held until next read completes.
- err  output  1  one-cycle timeout pulse, coincident with done.

Behaviour:
- Reset: async assert, state IDLE. cs=0, mosi=0, busy=0, done=0, err=0, rdata=0. Bit and timeout counters = 0. Reset mid-transfer aborts immediately; no done is issued.
- Clock and reset are one clock, asynchronous active-high reset, as already decided; port names clk and rst.
- IDLE: cs=0, mosi=0.
  - On newd=1: latch wr/addr/wdata, busy<=1, cs<=1, mosi<=wr (opcode bit), go to OP.
  - newd while busy is ignored; there is no queueing.
- OP: hold opcode bit one cycle. Load shift frame:
  - write: {wdata, addr}, ADDR_W+DATA_W bits.
  - read: addr, ADDR_W bits.
  - Go to SHIFT, count=0.
- SHIFT: mosi<=frame[count]; count++. After the last bit has been driven for one cycle, cs<=0, mosi<=0.
  - write: go to WAIT_DONE.
  - read: go to WAIT_RDY.
- WAIT_RDY: on ready=1, count<=0, go to CAPTURE.
- CAPTURE: each cycle rdata_sh[count]<=miso; count++. After DATA_W samples, go to WAIT_DONE.
  - First sample is taken the cycle after ready.
- WAIT_DONE: on op_done=1, done<=1 for one cycle, busy<=0, go to IDLE.
  - On a read, rdata updates from the shift register in the same cycle.
- op_done outside WAIT_DONE is ignored.
- ready outside WAIT_RDY is ignored.
- Latency:
  - write: 1 + ADDR_W + DATA_W cycles cs-high, then slave dependent.
  - read: 1 + ADDR_W cs-high, then ready, then DATA_W capture cycles.
- cs is never high for more than the frame; it drops before any waiting state.

Optional Feature:
- Macro SPI_MASTER_TIMEOUT_EN.
- Defined: a timeout counter runs in WAIT_RDY and WAIT_DONE and clears on state entry. If it reaches TIMEOUT, the block pulses done and err together, leaves rdata unchanged, clears busy and returns to IDLE. If op_done and expiry coincide, op_done wins: normal done, err=0.
- Undefined: no counter; err is tied 0; the block waits indefinitely.

Decomposition:
- Shared package spi_pkg holds:
  - state enum typedef (IDLE, OP, SHIFT, WAIT_RDY, CAPTURE, WAIT_DONE);
  - opcode constants OP_WRITE=1'b1, OP_READ=1'b0;
  - default ADDR_W/DATA_W;
  - memory depth 32.
- One natural sub-module, spi_bit_shifter: parameterised LSB-first shift register with load/shift/count-done. It is instantiated once for TX and once for RX capture.

Test Plan:
- Reset mid-SHIFT of a write (after 5 bits) -> cs, mosi, busy drop asynchronously; no done; next newd starts cleanly.
- Write addr=8'h05, wdata=8'hA5 -> cs high 17 cycles; mosi = 1, then 1,0,1,0,0,0,0,0, then 1,0,1,0,0,1,0,1. After op_done: done pulse, busy=0, rdata unchanged.
- Read addr=8'h05 after that write, slave model returns 8'hA5 -> cs high 9 cycles with opcode 0. Capture 8 bits starting the cycle after ready. done with rdata=8'hA5.
- newd asserted every cycle while busy -> exactly one transaction; mosi bits match the first latched request only.
- Spurious op_done during SHIFT, and ready during a write -> ignored; frame and done timing unchanged.
- SPI_MASTER_TIMEOUT_EN, TIMEOUT=64, read with slave never pulsing ready -> done and err pulse together 64 cycles after cs falls; rdata unchanged; busy=0.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared definitions for the SPI master slice.
// Holds the controller state encoding, the opcode bit values sent ahead of
// each frame, the default field widths, and the depth of the slave memory
// this master talks to.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    OP,
    SHIFT,
    WAIT_RDY,
    CAPTURE,
    WAIT_DONE
  } state_t;

  localparam logic OP_WRITE = 1'b1;
  localparam logic OP_READ  = 1'b0;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;
  localparam int MEM_DEPTH  = 32;

endpackage

// File: rtl/spi_bit_shifter.sv
// LSB-first shift register with a bit counter.
// load loads load_data and clears the count. shift moves every bit one place
// toward bit 0, inserts sin at the top and increments the count. last is high
// while the count equals last_idx, so the owner can stop after a variable
// number of bits.
// Ports:
//   clk, rst    clock, asynchronous active-high reset
//   load        load load_data, count <= 0 (wins over shift)
//   load_data   parallel value to load
//   shift       shift one place, count++
//   sin         bit inserted at the MSB on shift
//   last_idx    count value that flags the final bit
//   data        current register contents (bit 0 = next bit out)
//   last        count == last_idx
module spi_bit_shifter #(
  parameter int W  = 8,
  parameter int CW = $clog2(W + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [W-1:0]  load_data,
  input  logic          shift,
  input  logic          sin,
  input  logic [CW-1:0] last_idx,
  output logic [W-1:0]  data,
  output logic          last
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data <= '0;
      cnt  <= '0;
    end else if (load) begin
      data <= load_data;
      cnt  <= '0;
    end else if (shift) begin
      data <= {sin, data[W-1:1]};
      cnt  <= cnt + 1'b1;
    end
  end

  assign last = (cnt == last_idx);

endmodule

// File: rtl/spi_master.sv
// SPI initiator for the 32 x 8 SPI slave memory.
// A host request (newd with wr/addr/wdata) is latched in IDLE. The master then
// drives one opcode bit, followed by the address (reads) or the address and
// write data (writes), on mosi, one bit per clk, LSB first, with cs high for
// exactly that frame. Reads wait for the slave's ready pulse and capture
// DATA_W bits from miso, starting the cycle after ready. Every transaction
// ends when the slave pulses op_done, which produces a one-cycle done.
// Optional build macro SPI_MASTER_TIMEOUT_EN: bounds the waits for ready and
// op_done to TIMEOUT cycles each; on expiry done and err pulse together.
// Without the macro err is tied low and the waits are unbounded.
// Ports:
//   clk, rst     clock (also the bit clock), asynchronous active-high reset
//   newd         request strobe, sampled only in IDLE
//   wr           1 = write, 0 = read
//   addr, wdata  request address and write data
//   cs, mosi     chip select (active high) and serial data to the slave
//   miso         serial data from the slave
//   ready        slave pulse: read data starts next cycle
//   op_done      slave pulse: transaction finished
//   busy         high from accepted request until done
//   done         one-cycle completion pulse
//   rdata        last completed read result
//   err          one-cycle timeout pulse, coincident with done
module spi_master
  import spi_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
`ifdef SPI_MASTER_TIMEOUT_EN
  , parameter int TIMEOUT = 64
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              newd,
  input  logic              wr,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic              cs,
  output logic              mosi,
  input  logic              miso,
  input  logic              ready,
  input  logic              op_done,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] rdata,
  output logic              err
);

  localparam int FRAME_W = ADDR_W + DATA_W;
  localparam int TX_CW   = $clog2(FRAME_W + 1);
  localparam int RX_CW   = $clog2(DATA_W + 1);

  state_t              state, state_next;
  logic                wr_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;

  logic                tx_load, tx_shift, tx_last;
  logic                rx_load, rx_shift, rx_last;
  logic                finish, expire, tmo_hit;
  logic [FRAME_W-1:0]  frame, tx_data;
  logic [TX_CW-1:0]    tx_last_idx;
  logic [DATA_W-1:0]   rx_data;
  logic                tx_unused;

  // Reads only send the address, so the data half of the frame is zero and
  // the bit count stops ADDR_W bits in.
  assign frame       = (wr_q == OP_WRITE) ? {wdata_q, addr_q} : {{DATA_W{1'b0}}, addr_q};
  assign tx_last_idx = (wr_q == OP_WRITE) ? TX_CW'(FRAME_W - 1) : TX_CW'(ADDR_W - 1);

  // Only bit 0 of the transmit register reaches mosi.
  assign tx_unused = ^tx_data[FRAME_W-1:1];

  spi_bit_shifter #(.W(FRAME_W), .CW(TX_CW)) u_tx (
    .clk       (clk),
    .rst       (rst),
    .load      (tx_load),
    .load_data (frame),
    .shift     (tx_shift),
    .sin       (1'b0),
    .last_idx  (tx_last_idx),
    .data      (tx_data),
    .last      (tx_last)
  );

  spi_bit_shifter #(.W(DATA_W), .CW(RX_CW)) u_rx (
    .clk       (clk),
    .rst       (rst),
    .load      (rx_load),
    .load_data ({DATA_W{1'b0}}),
    .shift     (rx_shift),
    .sin       (miso),
    .last_idx  (RX_CW'(DATA_W - 1)),
    .data      (rx_data),
    .last      (rx_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // The request is captured only when IDLE accepts it, so newd while busy
  // cannot disturb a frame in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state == IDLE && newd) begin
      wr_q    <= wr;
      addr_q  <= addr;
      wdata_q <= wdata;
    end
  end

  // rdata only moves on a normally completed read; writes and timeouts
  // leave the previous result in place.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done  <= 1'b0;
      err   <= 1'b0;
      rdata <= '0;
    end else begin
      done <= finish | expire;
      err  <= expire;
      if (finish && wr_q == OP_READ) rdata <= rx_data;
    end
  end

`ifdef SPI_MASTER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT + 1);
  logic [TMO_W-1:0] tmo_cnt;

  // Restarts on every state change so WAIT_RDY and WAIT_DONE each get a
  // full TIMEOUT window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      tmo_cnt <= '0;
    else if (state_next != state || (state != WAIT_RDY && state != WAIT_DONE))
      tmo_cnt <= '0;
    else
      tmo_cnt <= tmo_cnt + 1'b1;
  end

  assign tmo_hit = (state == WAIT_RDY || state == WAIT_DONE) &&
                   (tmo_cnt == TMO_W'(TIMEOUT - 1));
`else
  assign tmo_hit = 1'b0;
`endif

  // cs spans exactly the opcode cycle plus the shift cycles; every waiting
  // state sees cs and mosi low. op_done is tested before expiry so a
  // coinciding op_done completes normally.
  always_comb begin
    state_next = state;
    tx_load    = 1'b0;
    tx_shift   = 1'b0;
    rx_load    = 1'b0;
    rx_shift   = 1'b0;
    finish     = 1'b0;
    expire     = 1'b0;
    cs         = 1'b0;
    mosi       = 1'b0;
    busy       = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (newd) state_next = OP;
      end
      OP: begin
        cs         = 1'b1;
        mosi       = wr_q;
        tx_load    = 1'b1;
        state_next = SHIFT;
      end
      SHIFT: begin
        cs       = 1'b1;
        mosi     = tx_data[0];
        tx_shift = 1'b1;
        if (tx_last) state_next = (wr_q == OP_WRITE) ? WAIT_DONE : WAIT_RDY;
      end
      WAIT_RDY: begin
        if (ready) begin
          rx_load    = 1'b1;
          state_next = CAPTURE;
        end else if (tmo_hit) begin
          expire     = 1'b1;
          state_next = IDLE;
        end
      end
      CAPTURE: begin
        rx_shift = 1'b1;
        if (rx_last) state_next = WAIT_DONE;
      end
      WAIT_DONE: begin
        if (op_done) begin
          finish     = 1'b1;
          state_next = IDLE;
        end else if (tmo_hit) begin
          expire     = 1'b1;
          state_next = IDLE;
        end
      end
      default: begin
        busy       = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_spi_master.sv
// Randomised scoreboard bench for spi_master.
// A behavioural slave (32 x 8 memory) decodes each cs frame, compares it to
// the frame expected for the issued request, and answers with ready/miso and
// op_done after random delays, optionally with spurious pulses. Requests push
// their expected completion (rdata, err) into a queue; a monitor pops it on
// every done and also checks done timing against the slave's op_done.
module tb_spi_master;
  import spi_pkg::*;

  localparam int TIMEOUT = 64;

  logic       clk = 1'b0;
  logic       rst;
  logic       newd = 1'b0, wr = 1'b0;
  logic [7:0] addr = 8'h00, wdata = 8'h00;
  logic       miso = 1'b0, ready = 1'b0, op_done = 1'b0;
  logic       cs, mosi, busy, done, err;
  logic [7:0] rdata;

  spi_master #(.ADDR_W(8), .DATA_W(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .newd    (newd),
    .wr      (wr),
    .addr    (addr),
    .wdata   (wdata),
    .cs      (cs),
    .mosi    (mosi),
    .miso    (miso),
    .ready   (ready),
    .op_done (op_done),
    .busy    (busy),
    .done    (done),
    .rdata   (rdata),
    .err     (err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    int          len;
    logic [16:0] bits;
  } frame_t;

  typedef struct {
    logic [7:0] rdata;
    logic       err;
  } resp_t;

  frame_t     frameQ[$];
  resp_t      respQ[$];
  logic [7:0] refMem[MEM_DEPTH];
  logic [7:0] slaveMem[MEM_DEPTH];
  logic [7:0] lastRead = 8'h00;
  bit         spuriousMode = 0;
  bit         noReady = 0;
  int         expDoneCyc = -1;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic waitIdle();
    int n = 0;
    while (busy !== 1'b0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (busy !== 1'b0) checkOutput("idle wait expired", busy, 0);
  endtask

  // Issues one request; the expected frame and completion come from the
  // request fields and the reference memory alone.
  task automatic applyStimulus(input logic w, input logic [7:0] a, input logic [7:0] d,
                               input bit hammer, input bit expectErr);
    frame_t f;
    resp_t  r;
    int     n;
    waitIdle();
    f.len  = w ? 17 : 9;
    f.bits = w ? {d, a, 1'b1} : {8'h00, a, 1'b0};
    frameQ.push_back(f);
    if (expectErr) begin
      r.rdata = lastRead;
      r.err   = 1'b1;
    end else if (w) begin
      refMem[int'(a) % MEM_DEPTH] = d;
      r.rdata = lastRead;
      r.err   = 1'b0;
    end else begin
      r.rdata  = refMem[int'(a) % MEM_DEPTH];
      lastRead = r.rdata;
      r.err    = 1'b0;
    end
    respQ.push_back(r);
    newd = 1'b1; wr = w; addr = a; wdata = d;
    @(negedge clk);
    n = 0;
    while (hammer && busy === 1'b1 && n < 500) begin
      newd = 1'b1; wr = 1'($urandom); addr = 8'($urandom); wdata = 8'($urandom);
      @(negedge clk);
      n++;
    end
    newd = 1'b0; wr = 1'($urandom); addr = 8'($urandom); wdata = 8'($urandom);
  endtask

  // Behavioural slave and frame monitor.
  int         phase = 0;
  int         delay = 0;
  int         bitIdx = 0;
  logic       sBits[$];
  logic [16:0] got;
  logic [7:0] rbyte, sAddr;
  frame_t     ef;

  always @(negedge clk) begin
    if (rst) begin
      phase = 0; sBits.delete(); ready = 1'b0; op_done = 1'b0; miso = 1'b0;
    end else begin
      ready = 1'b0; op_done = 1'b0; miso = 1'b0;
      case (phase)
        0: begin
          if (cs) begin
            sBits.push_back(mosi);
            if (spuriousMode) begin
              op_done = 1'($urandom_range(0, 1));
              ready   = 1'($urandom_range(0, 1));
            end
          end else if (sBits.size() != 0) begin
            got = '0;
            foreach (sBits[i]) if (i < 17) got[i] = sBits[i];
            checkOutput("mosi low after cs", mosi, 0);
            if (frameQ.size() == 0) begin
              checks++; fails++;
              $display("[TB] FAIL frame: got unexpected frame %0h, expected none", got);
            end else begin
              ef = frameQ.pop_front();
              checkOutput("frame length (cs-high cycles)", sBits.size(), ef.len);
              checkOutput("frame bits", got, ef.bits);
            end
            sBits.delete();
            sAddr      = got[8:1];
            expDoneCyc = -1;
            delay      = $urandom_range(0, 4);
            if (got[0]) begin
              slaveMem[int'(sAddr) % MEM_DEPTH] = got[16:9];
              phase = 2;
            end else begin
              rbyte = slaveMem[int'(sAddr) % MEM_DEPTH];
              if (noReady) begin
                phase = 5;
                expDoneCyc = cyc + TIMEOUT;
              end else phase = 1;
            end
          end
        end
        1: begin
          if (spuriousMode) op_done = 1'($urandom_range(0, 1));
          if (delay == 0) begin
            ready = 1'b1; bitIdx = 0; phase = 3;
          end else delay--;
        end
        3: begin
          miso = rbyte[bitIdx];
          bitIdx++;
          if (spuriousMode) begin
            ready   = 1'($urandom_range(0, 1));
            op_done = 1'($urandom_range(0, 1));
          end
          if (bitIdx == 8) begin
            phase = 2; delay = $urandom_range(0, 4);
          end
        end
        2: begin
          if (spuriousMode) ready = 1'b1;
          if (delay == 0) begin
            op_done = 1'b1; expDoneCyc = cyc + 1; phase = 0;
          end else delay--;
        end
        5: begin
          if (cs) begin
            sBits.push_back(mosi); phase = 0;
          end
        end
        default: phase = 0;
      endcase
    end
  end

  // Completion monitor.
  resp_t mr;
  always @(negedge clk) begin
    if (!rst && done === 1'b1) begin
      if (respQ.size() == 0) begin
        checks++; fails++;
        $display("[TB] FAIL done: got unexpected done pulse, expected none (cycle %0d)", cyc);
      end else begin
        mr = respQ.pop_front();
        checkOutput("rdata at done", rdata, mr.rdata);
        checkOutput("err at done", err, mr.err);
        checkOutput("busy at done", busy, 0);
        checkOutput("done cycle", cyc, expDoneCyc);
      end
    end
    if (!rst && err === 1'b1 && done !== 1'b1) begin
      checks++; fails++;
      $display("[TB] FAIL err: got err=1 with done=0, expected err only with done");
    end
  end

  initial begin
    int n;
    logic [7:0] a, d;
    foreach (refMem[i]) begin
      refMem[i] = 8'h00; slaveMem[i] = 8'h00;
    end
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset cs", cs, 0);
    checkOutput("reset mosi", mosi, 0);
    checkOutput("reset busy", busy, 0);
    checkOutput("reset done", done, 0);
    checkOutput("reset err", err, 0);
    checkOutput("reset rdata", rdata, 0);
    rst = 1'b0;
    @(negedge clk);

    // Abort a write five bits into the shift phase; no expectations queued.
    newd = 1'b1; wr = 1'b1; addr = 8'h05; wdata = 8'hA5;
    @(negedge clk);
    newd = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("mid-shift cs", cs, 1);
    checkOutput("mid-shift busy", busy, 1);
    checkOutput("mid-shift mosi (addr bit 4)", mosi, 0);
    #2 rst = 1'b1;
    #1;
    checkOutput("async reset cs", cs, 0);
    checkOutput("async reset mosi", mosi, 0);
    checkOutput("async reset busy", busy, 0);
    checkOutput("async reset done", done, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] directed write/read");
    applyStimulus(1'b1, 8'h05, 8'hA5, 0, 0);
    applyStimulus(1'b0, 8'h05, 8'h00, 0, 0);

    $display("[TB] newd held while busy");
    a = 8'($urandom_range(0, 31)); d = 8'($urandom);
    applyStimulus(1'b1, a, d, 1, 0);
    applyStimulus(1'b0, a, 8'h00, 1, 0);

    $display("[TB] spurious ready/op_done");
    waitIdle();
    spuriousMode = 1;
    applyStimulus(1'b1, 8'h1C, 8'h3E, 0, 0);
    applyStimulus(1'b0, 8'h1C, 8'h00, 0, 0);
    applyStimulus(1'b1, 8'h07, 8'hC3, 0, 0);
    waitIdle();
    spuriousMode = 0;

    $display("[TB] random traffic");
    for (int i = 0; i < 24; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 8'($urandom_range(0, 63)), 8'($urandom), 0, 0);
    end

`ifdef SPI_MASTER_TIMEOUT_EN
    $display("[TB] read timeout");
    waitIdle();
    noReady = 1;
    applyStimulus(1'b0, 8'h05, 8'h00, 0, 1);
    waitIdle();
    noReady = 0;
    applyStimulus(1'b0, 8'h05, 8'h00, 0, 0);
`endif

    n = 0;
    while (respQ.size() != 0 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    checkOutput("pending completions", respQ.size(), 0);
    checkOutput("pending frames", frameQ.size(), 0);
    checkOutput("final busy", busy, 0);
    checkOutput("final cs", cs, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
